fpu_addsub_ctrl: RTL

Sequencing and arbitration controller for the combinational `fp_add_sub` datapath. It accepts add/subtract requests from `NREQ` requesters using round-robin arbitration. For each granted request it orders the operands by exponent and aligns the smaller mantissa with a serial one-bit-per-cycle shifter. It then drives the datapath for one cycle and holds the registered result until the granted requester accepts it. It sits between the FPU issue ports and `fp_add_sub`, and it owns all operand swapping and alignment.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_addsub_ctrl_if.sv | 26 ++
 rtl/fpu_rr_arbiter.sv | 29 ++
 rtl/fpu_addsub_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: extended-precision operand format, operation codes and the
// add/sub controller state encoding.
package fpu_pkg;

    localparam int unsigned FP_PRECISION = 3;
    localparam int unsigned MANT_W       = 23 + FP_PRECISION;

    typedef struct packed {
        logic              sign_bit;
        logic [7:0]        exp;
        logic [MANT_W-1:0] mant;
    } IEEE_extended_fp;

    typedef enum logic [1:0] {
        fp_add = 2'd0,
        fp_sub = 2'd1,
        fp_mul = 2'd2,
        fp_div = 2'd3
    } fp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } fpu_addsub_state_t;

    function automatic logic is_addsub(input fp_op_t op);
        return (op == fp_add) || (op == fp_sub);
    endfunction

endpackage

// File: rtl/fpu_addsub_ctrl_if.sv
// Requester-side request/response bundle of the add/sub controller.
interface fpu_addsub_ctrl_if #(
    parameter int unsigned NREQ = 2
) ();
    import fpu_pkg::*;

    logic            [NREQ-1:0] req_valid;
    logic            [NREQ-1:0] req_ready;
    IEEE_extended_fp [NREQ-1:0] req_x1;
    IEEE_extended_fp [NREQ-1:0] req_x2;
    fp_op_t          [NREQ-1:0] req_op;
    logic            [NREQ-1:0] rsp_valid;
    logic            [NREQ-1:0] rsp_ready;
    IEEE_extended_fp            rsp_ans;
    logic                       rsp_err;

    modport master (
        output req_valid, req_x1, req_x2, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_ans, rsp_err
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_ans, rsp_err
    );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module fpu_rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/fpu_addsub_ctrl.sv
// Arbitrates add/sub requests, orders and serially aligns operands, drives the
// combinational fp_add_sub datapath for one cycle and holds the result.
module fpu_addsub_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned PRECISION = FP_PRECISION,
    parameter int unsigned NREQ      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fpu_addsub_ctrl_if.slave        bus,
    output IEEE_extended_fp         dp_x1,
    output IEEE_extended_fp         dp_x2,
    output fp_op_t                  dp_op,
    output logic                    dp_switched,
    input  IEEE_extended_fp         dp_ans,
    output logic                    busy
);
    localparam int unsigned IDX_W     = $clog2(NREQ);
    localparam int unsigned MAX_SHIFT = 24 + PRECISION;
    localparam int unsigned CNT_W     = $clog2(MAX_SHIFT + 1);

    if (PRECISION != FP_PRECISION) begin : g_precision_mismatch
        $error("PRECISION must equal fpu_pkg::FP_PRECISION");
    end

    fpu_addsub_state_t state;
    logic [IDX_W-1:0]  rr_ptr, gnt_idx, arb_idx;
    logic [NREQ-1:0]   arb_grant;
    logic              arb_any;
    IEEE_extended_fp   x1_q, x2_q, ans_q;
    fp_op_t            op_q;
    logic [CNT_W-1:0]  count;
    logic              first_shift, switched, err_q;

    IEEE_extended_fp   in_x1, in_x2, ord_x1, ord_x2;
    fp_op_t            in_op;
    logic [7:0]        exp_diff;
    logic [CNT_W-1:0]  load_count;
    logic [MANT_W-1:0] shifted;

    fpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign bus.req_ready = (state == ST_IDLE) ? arb_grant : '0;

    // Larger exponent goes to x1; a subtract keeps its value via a-b = (-b)-(-a).
    always_comb begin
        in_x1  = bus.req_x1[arb_idx];
        in_x2  = bus.req_x2[arb_idx];
        in_op  = bus.req_op[arb_idx];
        ord_x1 = in_x1;
        ord_x2 = in_x2;
        if (in_x2.exp > in_x1.exp) begin
            ord_x1 = in_x2;
            ord_x2 = in_x1;
            if (in_op == fp_sub) begin
                ord_x1.sign_bit = ~in_x2.sign_bit;
                ord_x2.sign_bit = ~in_x1.sign_bit;
            end
        end
        exp_diff   = ord_x1.exp - ord_x2.exp;
        load_count = (32'(exp_diff) > MAX_SHIFT) ? CNT_W'(MAX_SHIFT) : CNT_W'(exp_diff);
    end

    // Hidden bit enters on the first shift; bit 0 accumulates everything shifted out.
    assign shifted = {first_shift, x2_q.mant[MANT_W-1:1]} | {{(MANT_W-1){1'b0}}, x2_q.mant[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            op_q        <= fp_add;
            count       <= '0;
            first_shift <= 1'b0;
            switched    <= 1'b0;
            ans_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_idx <= arb_idx;
                        op_q    <= in_op;
                        if (is_addsub(in_op)) begin
                            x1_q        <= ord_x1;
                            x2_q        <= ord_x2;
                            count       <= load_count;
                            switched    <= (load_count != '0);
                            first_shift <= 1'b1;
                            err_q       <= 1'b0;
                            state       <= ST_ALIGN;
                        end else begin
                            err_q <= 1'b1;
                            ans_q <= '0;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (count != '0) begin
                        x2_q.mant   <= shifted;
                        first_shift <= 1'b0;
                        count       <= count - CNT_W'(1);
                    end else begin
                        x2_q.exp <= x1_q.exp;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    ans_q <= dp_ans;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready[gnt_idx]) begin
                        rr_ptr <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDX_W'(1);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dp_x1       = '0;
        dp_x2       = '0;
        dp_op       = fp_add;
        dp_switched = 1'b0;
        if (state == ST_EXEC) begin
            dp_x1       = x1_q;
            dp_x2       = x2_q;
            dp_op       = op_q;
            dp_switched = switched;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state == ST_RESP) bus.rsp_valid[gnt_idx] = 1'b1;
    end

    assign bus.rsp_ans = ans_q;
    assign bus.rsp_err = err_q;
    assign busy        = (state != ST_IDLE);
endmodule
